// File: rtl/wd_pkg.sv
// Shared types and default constants for the watchdog safe-shutdown sequencer.
// The state encoding is visible on the debug port, so its values are fixed.
package wd_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RAMP_DN  = 3'd1,
        HOLD     = 3'd2,
        COOLDOWN = 3'd3,
        RESTORE  = 3'd4
    } wd_sd_state_t;

    localparam int WD_AMP_WIDTH       = 8;
    localparam int WD_RAMP_DIV        = 16;
    localparam int WD_HOLD_CYCLES     = 64;
    localparam int WD_COOLDOWN_CYCLES = 256;
    localparam int WD_CNT_WIDTH       = 8;

    function automatic int wd_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/wd_safe_shutdown.sv
// Watchdog shutdown sequencer: ramps carrier down, holds downstream reset, cools down, ramps back up.
// All outputs registered (one cycle from sampled input); no backpressure, force_reset is level-sampled.
module wd_safe_shutdown
    import wd_pkg::*;
#(
    parameter int AMP_WIDTH       = WD_AMP_WIDTH,
    parameter int RAMP_DIV        = WD_RAMP_DIV,
    parameter int HOLD_CYCLES     = WD_HOLD_CYCLES,
    parameter int COOLDOWN_CYCLES = WD_COOLDOWN_CYCLES,
    parameter int CNT_WIDTH       = WD_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 force_reset,
    input  logic                 fault_clear,
    output logic [AMP_WIDTH-1:0] amp_scale,
    output logic                 rf_enable,
    output logic                 sys_rstn,
    output logic                 fault_latched,
    output logic [CNT_WIDTH-1:0] reset_count,
    output logic                 busy,
    output logic [2:0]           state_o
);

    localparam int TMR_MAX = wd_max3(RAMP_DIV, HOLD_CYCLES, COOLDOWN_CYCLES);
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0]     RAMP_LAST = TMR_W'(RAMP_DIV - 1);
    localparam logic [TMR_W-1:0]     HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0]     COOL_LAST = TMR_W'(COOLDOWN_CYCLES - 1);
    localparam logic [AMP_WIDTH-1:0] AMP_FULL  = '1;
    localparam logic [AMP_WIDTH-1:0] AMP_PRE   = AMP_FULL - 1'b1;
    localparam logic [CNT_WIDTH-1:0] CNT_FULL  = '1;

    wd_sd_state_t         state_q, state_d;
    logic [TMR_W-1:0]     tmr_q, tmr_d;
    logic [AMP_WIDTH-1:0] amp_q, amp_d;
    logic                 rf_q, rf_d;
    logic                 srn_q, srn_d;
    logic                 fault_q, fault_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic [CNT_WIDTH-1:0] cnt_inc;

    assign cnt_inc = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + 1'b1;

    // Reset lands in HOLD so power-up runs the same soft-start as a watchdog recovery.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= HOLD;
            tmr_q   <= '0;
            amp_q   <= '0;
            rf_q    <= 1'b0;
            srn_q   <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            amp_q   <= amp_d;
            rf_q    <= rf_d;
            srn_q   <= srn_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q + 1'b1;
        amp_d   = amp_q;
        rf_d    = rf_q;
        srn_d   = srn_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                tmr_d = '0;
                amp_d = AMP_FULL;
                rf_d  = 1'b1;
                srn_d = 1'b1;
                if (fault_clear) fault_d = 1'b0;
                if (force_reset) begin
                    state_d = RAMP_DN;
                    fault_d = 1'b1;
                end
            end

            // Amplitude reaching zero is observed for one cycle before HOLD.
            RAMP_DN: begin
                if (amp_q == '0) begin
                    state_d = HOLD;
                    tmr_d   = '0;
                    cnt_d   = cnt_inc;
                    rf_d    = 1'b0;
                    srn_d   = 1'b0;
                end else if (tmr_q == RAMP_LAST) begin
                    amp_d = amp_q - 1'b1;
                    tmr_d = '0;
                end
            end

            HOLD: begin
                amp_d = '0;
                rf_d  = 1'b0;
                srn_d = 1'b0;
                if (tmr_q == HOLD_LAST) begin
                    state_d = COOLDOWN;
                    tmr_d   = '0;
                    srn_d   = 1'b1;
                end
            end

            COOLDOWN: begin
                amp_d = '0;
                rf_d  = 1'b0;
                srn_d = 1'b1;
                if (tmr_q == COOL_LAST) begin
                    tmr_d = '0;
                    if (force_reset) begin
                        state_d = HOLD;
                        cnt_d   = cnt_inc;
                        fault_d = 1'b1;
                        srn_d   = 1'b0;
                    end else begin
                        state_d = RESTORE;
                        rf_d    = 1'b1;
                    end
                end
            end

            // A trip here ramps down from wherever the amplitude currently is.
            RESTORE: begin
                rf_d  = 1'b1;
                srn_d = 1'b1;
                if (force_reset) begin
                    state_d = RAMP_DN;
                    tmr_d   = '0;
                    fault_d = 1'b1;
                end else if (amp_q == AMP_FULL) begin
                    state_d = IDLE;
                    tmr_d   = '0;
                end else if (tmr_q == RAMP_LAST) begin
                    amp_d = amp_q + 1'b1;
                    tmr_d = '0;
                    if (amp_q == AMP_PRE) state_d = IDLE;
                end
            end

            default: begin
                state_d = HOLD;
                tmr_d   = '0;
                amp_d   = '0;
                rf_d    = 1'b0;
                srn_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign amp_scale     = amp_q;
    assign rf_enable     = rf_q;
    assign sys_rstn      = srn_q;
    assign fault_latched = fault_q;
    assign reset_count   = cnt_q;
    assign busy          = busy_q;
    assign state_o       = 3'(state_q);

endmodule

// File: tb/tb_wd_safe_shutdown.sv
// Scoreboard bench: each expected state entry (outputs on entry, cycles spent in the prior state)
// is queued by the stimulus and checked by a monitor whenever state_o changes.
module tb_wd_safe_shutdown;
    import wd_pkg::*;

    logic       clk = 1'b0;
    logic       rstn;
    logic       force_reset;
    logic       fault_clear;
    logic [3:0] amp_scale;
    logic       rf_enable;
    logic       sys_rstn;
    logic       fault_latched;
    logic [1:0] reset_count;
    logic       busy;
    logic [2:0] state_o;

    wd_safe_shutdown #(
        .AMP_WIDTH(4), .RAMP_DIV(2), .HOLD_CYCLES(4), .COOLDOWN_CYCLES(3), .CNT_WIDTH(2)
    ) dut (
        .clk(clk), .rstn(rstn), .force_reset(force_reset), .fault_clear(fault_clear),
        .amp_scale(amp_scale), .rf_enable(rf_enable), .sys_rstn(sys_rstn),
        .fault_latched(fault_latched), .reset_count(reset_count), .busy(busy), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic [2:0] st;
        int         dwell;
        logic [3:0] amp;
        logic       rf;
        logic       srn;
        logic       flt;
        logic [1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic push(input string nm, input wd_sd_state_t st, input int dwell, input int amp,
                        input bit rf, input bit srn, input bit flt, input int cnt);
        exp_t e;
        e.nm = nm; e.st = st; e.dwell = dwell; e.amp = 4'(amp);
        e.rf = rf; e.srn = srn; e.flt = flt; e.cnt = 2'(cnt);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, req);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_state"}, int'(state_o), int'(HOLD));
        chk({tag, "_amp"}, int'(amp_scale), 0);
        chk({tag, "_rf"}, int'(rf_enable), 0);
        chk({tag, "_sys_rstn"}, int'(sys_rstn), 0);
        chk({tag, "_fault"}, int'(fault_latched), 0);
        chk({tag, "_count"}, int'(reset_count), 0);
        chk({tag, "_busy"}, int'(busy), 1);
    endtask

    // Monitor: a change of state_o is the DUT's "output event".
    logic [2:0] prev_st = 3'd0;
    int         dwell = 0;
    exp_t       me;
    always @(negedge clk) begin
        if (!rstn) begin
            prev_st = state_o;
            dwell   = 0;
        end else if (state_o == prev_st) begin
            dwell++;
        end else begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_transition: got state %0d after %0d cycles in %0d, want none",
                         state_o, dwell, prev_st);
            end else begin
                me = exp_q.pop_front();
                if (state_o !== me.st || amp_scale !== me.amp || rf_enable !== me.rf ||
                    sys_rstn !== me.srn || fault_latched !== me.flt || reset_count !== me.cnt ||
                    busy !== (me.st != 3'(IDLE)) || (me.dwell >= 0 && dwell != me.dwell)) begin
                    n_bad++;
                    $display("FAIL %s: got st=%0d amp=%0d rf=%0b srn=%0b flt=%0b cnt=%0d busy=%0b dwell=%0d, want st=%0d amp=%0d rf=%0b srn=%0b flt=%0b cnt=%0d busy=%0b dwell=%0d",
                             me.nm, state_o, amp_scale, rf_enable, sys_rstn, fault_latched, reset_count,
                             busy, dwell, me.st, me.amp, me.rf, me.srn, me.flt, me.cnt,
                             (me.st != 3'(IDLE)), me.dwell);
                end
            end
            prev_st = state_o;
            dwell   = 1;
        end
    end

    task automatic wait_state(input wd_sd_state_t st, input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (state_o == 3'(st)) return;
        end
        n_cmp++; n_bad++;
        $display("FAIL wait_state: got state %0d, want %0d within %0d cycles", state_o, st, budget);
    endtask

    task automatic wait_amp(input int amp, input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (int'(amp_scale) == amp) return;
        end
        n_cmp++; n_bad++;
        $display("FAIL wait_amp: got amp %0d, want %0d within %0d cycles", amp_scale, amp, budget);
    endtask

    task automatic wait_drain(input string nm, input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0) return;
        end
        n_cmp++; n_bad++;
        $display("FAIL %s_drain: got %0d pending entries, want 0", nm, exp_q.size());
        exp_q.delete();
    endtask

    task automatic push_power_on();
        push("pon_cooldown", COOLDOWN, 4, 0, 0, 1, 0, 0);
        push("pon_restore", RESTORE, 3, 0, 1, 1, 0, 0);
        push("pon_idle", IDLE, 30, 15, 1, 1, 0, 0);
    endtask

    initial begin
        rstn = 1'b0; force_reset = 1'b0; fault_clear = 1'b0;
        #12;
        chk_reset_values("reset");

        // Power-on soft start.
        push_power_on();
        @(posedge clk); #2 rstn = 1'b1;
        wait_drain("power_on", 200);

        // Single-cycle trip from IDLE; fault_clear during COOLDOWN must not clear.
        push("trip_ramp_dn", RAMP_DN, -1, 15, 1, 1, 1, 0);
        push("trip_hold", HOLD, 31, 0, 0, 0, 1, 1);
        push("trip_cooldown", COOLDOWN, 4, 0, 0, 1, 1, 1);
        push("trip_restore", RESTORE, 3, 0, 1, 1, 1, 1);
        push("trip_idle", IDLE, 30, 15, 1, 1, 1, 1);
        @(negedge clk); force_reset = 1'b1;
        @(negedge clk); force_reset = 1'b0;
        wait_state(COOLDOWN, 100);
        fault_clear = 1'b1;
        @(negedge clk); fault_clear = 1'b0;
        chk("clear_in_cooldown", int'(fault_latched), 1);
        wait_drain("trip", 200);

        // fault_clear in IDLE clears the flag.
        @(negedge clk); fault_clear = 1'b1;
        @(negedge clk); fault_clear = 1'b0;
        chk("clear_in_idle", int'(fault_latched), 0);

        // Coincident set/clear, then a persistent fault looping through HOLD until the counter saturates.
        push("pers_ramp_dn", RAMP_DN, -1, 15, 1, 1, 1, 1);
        push("pers_hold1", HOLD, 31, 0, 0, 0, 1, 2);
        push("pers_cool1", COOLDOWN, 4, 0, 0, 1, 1, 2);
        push("pers_hold2", HOLD, 3, 0, 0, 0, 1, 3);
        push("pers_cool2", COOLDOWN, 4, 0, 0, 1, 1, 3);
        push("pers_hold3", HOLD, 3, 0, 0, 0, 1, 3);
        push("pers_cool3", COOLDOWN, 4, 0, 0, 1, 1, 3);
        push("pers_hold4", HOLD, 3, 0, 0, 0, 1, 3);
        push("pers_cool4", COOLDOWN, 4, 0, 0, 1, 1, 3);
        push("pers_restore", RESTORE, 3, 0, 1, 1, 1, 3);
        push("pers_idle", IDLE, 30, 15, 1, 1, 1, 3);
        @(negedge clk); force_reset = 1'b1; fault_clear = 1'b1;
        @(negedge clk); fault_clear = 1'b0;
        chk("clear_vs_set", int'(fault_latched), 1);
        for (int i = 0; i < 4; i++) begin
            wait_state(HOLD, 100);
            wait_state(COOLDOWN, 100);
        end
        force_reset = 1'b0;
        wait_drain("persistent", 200);

        // Trip while RESTORE is at amplitude 6.
        push("rs_ramp_dn", RAMP_DN, -1, 15, 1, 1, 1, 3);
        push("rs_hold", HOLD, 31, 0, 0, 0, 1, 3);
        push("rs_cool", COOLDOWN, 4, 0, 0, 1, 1, 3);
        push("rs_restore", RESTORE, 3, 0, 1, 1, 1, 3);
        push("rs_ramp_dn6", RAMP_DN, 13, 6, 1, 1, 1, 3);
        push("rs_hold6", HOLD, 13, 0, 0, 0, 1, 3);
        push("rs_cool6", COOLDOWN, 4, 0, 0, 1, 1, 3);
        push("rs_restore6", RESTORE, 3, 0, 1, 1, 1, 3);
        push("rs_idle", IDLE, 30, 15, 1, 1, 1, 3);
        @(negedge clk); force_reset = 1'b1;
        @(negedge clk); force_reset = 1'b0;
        wait_state(RESTORE, 100);
        wait_amp(6, 40);
        force_reset = 1'b1;
        @(negedge clk); force_reset = 1'b0;
        wait_drain("restore_trip", 300);

        // Asynchronous reset in the middle of a ramp-down.
        push("ar_ramp_dn", RAMP_DN, -1, 15, 1, 1, 1, 3);
        @(negedge clk); force_reset = 1'b1;
        @(negedge clk); force_reset = 1'b0;
        wait_amp(9, 40);
        chk("ar_pre_state", int'(state_o), int'(RAMP_DN));
        #1 rstn = 1'b0;
        #1 chk_reset_values("async");
        wait_drain("async_pre", 2);
        push_power_on();
        @(posedge clk); @(posedge clk); #2 rstn = 1'b1;
        wait_drain("async_power_on", 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
